// File: rtl/chronologic_pkg.sv
// Shared types and defaults for the a/b/c handshake rule checker.
// The syndrome records which half of the rule broke on the most recent failure.
package chronologic_pkg;

  localparam int CNT_W_DEFAULT = 16;

  typedef struct packed {
    logic c_high;
    logic b_low;
  } fail_syndrome_t;

  typedef logic [CNT_W_DEFAULT-1:0] chk_cnt_t;

endpackage

// File: rtl/chronologic_if.sv
// Tap and status bundle between the observed design (master) and the checker (slave).
interface chronologic_if #(parameter int CNT_W = chronologic_pkg::CNT_W_DEFAULT);
  import chronologic_pkg::*;

  logic             enable;
  logic             clear;
  logic             signal_a;
  logic             signal_b;
  logic             signal_c;
  logic             pending;
  logic             pass_pulse;
  logic             fail_pulse;
  logic [CNT_W-1:0] pass_count;
  logic [CNT_W-1:0] fail_count;
  logic             error_sticky;
  logic [CNT_W-1:0] first_fail_time;
  fail_syndrome_t   fail_syndrome;

  modport master (
    output enable, clear, signal_a, signal_b, signal_c,
    input  pending, pass_pulse, fail_pulse, pass_count, fail_count,
           error_sticky, first_fail_time, fail_syndrome
  );

  modport slave (
    input  enable, clear, signal_a, signal_b, signal_c,
    output pending, pass_pulse, fail_pulse, pass_count, fail_count,
           error_sticky, first_fail_time, fail_syndrome
  );

endinterface

// File: rtl/chronologic_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module chronologic_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/chronologic.sv
// Runtime checker: a trigger (a & ~b) must be followed one edge later by ~c & b.
// Produces verdict pulses, saturating counts, a sticky error and first-fail debug info.
module chronologic
  import chronologic_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input logic         clk,
  input logic         rst,
  chronologic_if.slave bus
);

  logic             pending_q, pending_d;
  logic             pass_pulse_q, pass_pulse_d;
  logic             fail_pulse_q, fail_pulse_d;
  logic             error_sticky_q, error_sticky_d;
  logic [CNT_W-1:0] first_fail_time_q, first_fail_time_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  fail_syndrome_t   fail_syndrome_q, fail_syndrome_d;

  logic trigger;
  logic ok;
  logic pass_inc;
  logic fail_inc;

  assign trigger  = bus.enable & bus.signal_a & ~bus.signal_b;
  assign ok       = ~bus.signal_c & bus.signal_b;
  assign pass_inc = ~bus.clear & pending_q & ok;
  assign fail_inc = ~bus.clear & pending_q & ~ok;

  // Timestamps use the counter value this edge produces, so a failure at edge N reads N.
  always_comb begin
    cycle_cnt_d       = cycle_cnt_q + CNT_W'(1);
    pending_d         = trigger;
    pass_pulse_d      = pass_inc;
    fail_pulse_d      = fail_inc;
    error_sticky_d    = error_sticky_q;
    first_fail_time_d = first_fail_time_q;
    fail_syndrome_d   = fail_syndrome_q;
    if (bus.clear) begin
      pending_d         = 1'b0;
      error_sticky_d    = 1'b0;
      first_fail_time_d = '0;
      fail_syndrome_d   = '0;
    end else if (fail_inc) begin
      error_sticky_d         = 1'b1;
      fail_syndrome_d.c_high = bus.signal_c;
      fail_syndrome_d.b_low  = ~bus.signal_b;
      if (!error_sticky_q) begin
        first_fail_time_d = cycle_cnt_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q         <= 1'b0;
      pass_pulse_q      <= 1'b0;
      fail_pulse_q      <= 1'b0;
      error_sticky_q    <= 1'b0;
      first_fail_time_q <= '0;
      cycle_cnt_q       <= '0;
      fail_syndrome_q   <= '0;
    end else begin
      pending_q         <= pending_d;
      pass_pulse_q      <= pass_pulse_d;
      fail_pulse_q      <= fail_pulse_d;
      error_sticky_q    <= error_sticky_d;
      first_fail_time_q <= first_fail_time_d;
      cycle_cnt_q       <= cycle_cnt_d;
      fail_syndrome_q   <= fail_syndrome_d;
    end
  end

  logic [CNT_W-1:0] pass_count_w;
  logic [CNT_W-1:0] fail_count_w;

  chronologic_sat_cnt #(.W(CNT_W)) u_pass_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pass_inc),
    .clr   (bus.clear),
    .count (pass_count_w)
  );

  chronologic_sat_cnt #(.W(CNT_W)) u_fail_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (fail_inc),
    .clr   (bus.clear),
    .count (fail_count_w)
  );

  assign bus.pending         = pending_q;
  assign bus.pass_pulse      = pass_pulse_q;
  assign bus.fail_pulse      = fail_pulse_q;
  assign bus.pass_count      = pass_count_w;
  assign bus.fail_count      = fail_count_w;
  assign bus.error_sticky    = error_sticky_q;
  assign bus.first_fail_time = first_fail_time_q;
  assign bus.fail_syndrome   = fail_syndrome_q;

endmodule

// File: tb/tb_chronologic.sv
// Drives the checker with directed and random tap patterns and compares every
// status output against an edge-by-edge reference of the handshake rule.
module tb_chronologic;

  localparam int W   = 4;
  localparam int MAX = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  chronologic_if #(.CNT_W(W)) bus ();

  chronologic #(.CNT_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;

  int mPending, mPass, mFail, mPassCnt, mFailCnt, mSticky, mFirstFail, mSyn, mEdges;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("pending",         32'(bus.pending),         32'(mPending));
    checkOutput("pass_pulse",      32'(bus.pass_pulse),      32'(mPass));
    checkOutput("fail_pulse",      32'(bus.fail_pulse),      32'(mFail));
    checkOutput("pass_count",      32'(bus.pass_count),      32'(mPassCnt));
    checkOutput("fail_count",      32'(bus.fail_count),      32'(mFailCnt));
    checkOutput("error_sticky",    32'(bus.error_sticky),    32'(mSticky));
    checkOutput("first_fail_time", 32'(bus.first_fail_time), 32'(mFirstFail));
    checkOutput("fail_syndrome",   32'(bus.fail_syndrome),   32'(mSyn));
  endtask

  task automatic modelReset();
    mPending = 0; mPass = 0; mFail = 0; mPassCnt = 0; mFailCnt = 0;
    mSticky = 0; mFirstFail = 0; mSyn = 0; mEdges = 0;
  endtask

  // Reference: one call per clock edge, using the tap values seen at that edge.
  task automatic modelEdge(input bit en, input bit clr, input bit a, input bit b, input bit c);
    bit verdictOk;
    mEdges = (mEdges + 1) % (MAX + 1);
    mPass = 0;
    mFail = 0;
    if (clr) begin
      mPending = 0; mPassCnt = 0; mFailCnt = 0;
      mSticky = 0; mFirstFail = 0; mSyn = 0;
    end else begin
      if (mPending != 0) begin
        verdictOk = !c && b;
        if (verdictOk) begin
          mPass = 1;
          if (mPassCnt < MAX) mPassCnt++;
        end else begin
          mFail = 1;
          if (mFailCnt < MAX) mFailCnt++;
          if (mSticky == 0) mFirstFail = mEdges;
          mSticky = 1;
          mSyn = (c ? 2 : 0) + (b ? 0 : 1);
        end
      end
      mPending = (en && a && !b) ? 1 : 0;
    end
  endtask

  // Called 1 time unit after a rising edge; returns at the same phase of the next edge.
  task automatic applyStimulus(input bit en, input bit clr, input bit a, input bit b, input bit c);
    bus.enable   = en;
    bus.clear    = clr;
    bus.signal_a = a;
    bus.signal_b = b;
    bus.signal_c = c;
    @(posedge clk);
    modelEdge(en, clr, a, b, c);
    #1;
    checkAll();
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    modelReset();
    checkAll();
  endtask

  initial begin
    bus.enable   = 1'b1;
    bus.clear    = 1'b0;
    bus.signal_a = 1'b0;
    bus.signal_b = 1'b0;
    bus.signal_c = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkAll();

    // Edges 1-2 idle, trigger at edge 3 then violation at edge 4 (c high, b low).
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 0, 1);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("t1_first_fail_is_4", 32'(bus.first_fail_time), 32'd4);
    checkOutput("t1_syndrome_11", 32'(bus.fail_syndrome), 32'd3);

    // Passing check at edges 6/7.
    applyStimulus(1, 0, 0, 1, 0);
    applyStimulus(1, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("t2_pass_pulse", 32'(bus.pass_pulse), 32'd1);

    // Non-trigger patterns.
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 0, 1);

    // Trigger held for three edges: back-to-back checks.
    applyStimulus(1, 0, 1, 0, 0);
    applyStimulus(1, 0, 1, 0, 0);
    applyStimulus(1, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("t4_first_fail_kept", 32'(bus.first_fail_time), 32'd4);

    // Clear wins over an in-flight verdict, then reset mid-check.
    applyStimulus(1, 0, 1, 0, 1);
    applyStimulus(1, 1, 1, 0, 1);
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(1, 0, 1, 0, 1);
    pulseReset();
    applyStimulus(1, 0, 0, 0, 1);

    // Saturation of the pass counter, then disabled triggers.
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1, 0, 1, 0, 0);
      applyStimulus(1, 0, 0, 1, 0);
    end
    checkOutput("t6_pass_saturated", 32'(bus.pass_count), 32'(MAX));
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 1);

    // Random traffic with occasional clear and reset.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 79) == 0) pulseReset();
      applyStimulus($urandom_range(0, 7) != 0, $urandom_range(0, 24) == 0,
                    $urandom_range(0, 2) != 0, $urandom_range(0, 1) != 0,
                    $urandom_range(0, 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
